moldudp64_tx: RTL and testbench

- MoldUDP64 packetizer: the transmit counterpart of the `moldudp64` receiver.
- Takes one packet descriptor (session id, message count) followed by that many messages on the `mold_msg_*` interface.
- Emits the complete MoldUDP64 payload on a 64-bit AXI-stream toward the UDP/IP encapsulation: 20-byte header, then a 2-byte length prefix before each message, packed with no gaps.
- Keeps the sequence number internally and supports heartbeat and end-of-session packets.

---
 rtl/moldudp64_tx.sv | 183 ++++++++++++++++++
 tb/tb_moldudp64_tx.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_tx.sv
`timescale 1ns/1ps
// moldudp64_tx: MoldUDP64 packetizer.
// Accepts a packet descriptor followed by its messages. It emits the 20-byte
// header and the length-prefixed messages as a gap-free 64-bit AXI-stream.
// All bytes pass through a 24-byte shift buffer. Its head is always lane 0 of
// the outgoing beat, so appends at the tail never disturb a stalled beat.
module moldudp64_tx #(
    parameter int          AXI_DATA_W  = 64,
    parameter int          AXI_KEEP_W  = AXI_DATA_W/8,
    parameter int          SID_W       = 80,
    parameter int          SEQ_NUM_W   = 64,
    parameter int          ML_W        = 16,
    parameter logic [15:0] EOS_MSG_CNT = 16'hffff
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pkt_v_i,
    input  logic [SID_W-1:0]      pkt_sid_i,
    input  logic [ML_W-1:0]       pkt_msg_cnt_i,
    output logic                  pkt_ready_o,
    input  logic                  seq_num_load_v_i,
    input  logic [SEQ_NUM_W-1:0]  seq_num_load_i,
    output logic [SEQ_NUM_W-1:0]  seq_num_o,
    input  logic                  mold_msg_v_i,
    input  logic                  mold_msg_start_i,
    input  logic [ML_W-1:0]       mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  mold_msg_ready_o,
    output logic                  udp_axis_tvalid_o,
    output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
    output logic                  udp_axis_tlast_o,
    output logic                  udp_axis_tuser_o,
    input  logic                  udp_axis_tready_i
);

    localparam int BUF_BYTES = 24;
    localparam int PUSH_MAX  = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MSG   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [7:0]           byte_buf   [0:BUF_BYTES-1];
    logic [7:0]           nxt_buf    [0:BUF_BYTES-1];
    logic [7:0]           push_bytes [0:PUSH_MAX-1];
    logic [4:0]           fill;
    logic [4:0]           fill_nxt;
    logic [4:0]           push_n;
    logic [3:0]           beat_n;
    logic [3:0]           pop_n;
    logic [3:0]           msg_pop;
    logic [SEQ_NUM_W-1:0] seq_num;
    logic [ML_W-1:0]      msgs_left;
    logic [ML_W-1:0]      bytes_left;
    logic [ML_W-1:0]      bytes_rem;
    logic                 out_valid;
    logic                 pkt_fire;
    logic                 msg_fire;
    logic                 pop_fire;

    assign pkt_ready_o      = (state == ST_IDLE) && (fill == 5'd0);
    assign mold_msg_ready_o = (state == ST_MSG) && (fill <= 5'd14);
    assign seq_num_o        = seq_num;
    assign pkt_fire         = pkt_v_i && pkt_ready_o;
    assign msg_fire         = mold_msg_v_i && mold_msg_ready_o;
    assign pop_fire         = out_valid && udp_axis_tready_i;
    assign pop_n            = pop_fire ? beat_n : 4'd0;

    // Present the head of the buffer as the outgoing beat, zeroing unused lanes
    always_comb begin
        out_valid = (fill >= 5'd8) || ((state == ST_DRAIN) && (fill != 5'd0));
        beat_n    = (fill >= 5'd8) ? 4'd8 : fill[3:0];
        udp_axis_tvalid_o = out_valid;
        udp_axis_tlast_o  = out_valid && (state == ST_DRAIN) && (fill <= 5'd8);
        udp_axis_tuser_o  = 1'b0;
        udp_axis_tkeep_o  = '0;
        udp_axis_tdata_o  = '0;
        for (int k = 0; k < AXI_KEEP_W; k++) begin
            if (out_valid && (k < int'(beat_n))) begin
                udp_axis_tkeep_o[k]       = 1'b1;
                udp_axis_tdata_o[8*k +: 8] = byte_buf[k];
            end
        end
    end

    // Count valid lanes in the incoming message beat and the bytes still owed
    always_comb begin
        msg_pop = 4'd0;
        for (int k = 0; k < AXI_KEEP_W; k++) begin
            if (mold_msg_mask_i[k]) msg_pop = msg_pop + 4'd1;
        end
        bytes_rem = (mold_msg_start_i ? mold_msg_len_i : bytes_left) - ML_W'(msg_pop);
    end

    // Assemble the bytes appended this cycle: a header or a message beat
    always_comb begin
        push_n = 5'd0;
        for (int j = 0; j < PUSH_MAX; j++) push_bytes[j] = 8'd0;
        if (pkt_fire) begin
            for (int i = 0; i < 10; i++) push_bytes[i] = pkt_sid_i[SID_W-1-8*i -: 8];
            for (int i = 0; i < 8; i++) push_bytes[10+i] = seq_num[SEQ_NUM_W-1-8*i -: 8];
            push_bytes[18] = pkt_msg_cnt_i[15:8];
            push_bytes[19] = pkt_msg_cnt_i[7:0];
            push_n = 5'd20;
        end else if (msg_fire) begin
            if (mold_msg_start_i) begin
                push_bytes[0] = mold_msg_len_i[15:8];
                push_bytes[1] = mold_msg_len_i[7:0];
                for (int k = 0; k < AXI_KEEP_W; k++) push_bytes[2+k] = mold_msg_data_i[8*k +: 8];
                push_n = 5'd2 + 5'(msg_pop);
            end else begin
                for (int k = 0; k < AXI_KEEP_W; k++) push_bytes[k] = mold_msg_data_i[8*k +: 8];
                push_n = 5'(msg_pop);
            end
        end
    end

    // Shift out the popped head bytes, then append the new bytes at the tail
    always_comb begin
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i + int'(pop_n) < BUF_BYTES) nxt_buf[i] = byte_buf[5'(i + int'(pop_n))];
            else                              nxt_buf[i] = 8'd0;
        end
        for (int j = 0; j < PUSH_MAX; j++) begin
            if ((j < int'(push_n)) && (int'(fill) - int'(pop_n) + j < BUF_BYTES))
                nxt_buf[5'(int'(fill) - int'(pop_n) + j)] = push_bytes[j];
        end
        fill_nxt = fill - 5'(pop_n) + push_n;
    end

    // Byte buffer and fill count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_BYTES; i++) byte_buf[i] <= 8'd0;
            fill <= 5'd0;
        end else begin
            for (int i = 0; i < BUF_BYTES; i++) byte_buf[i] <= nxt_buf[i];
            fill <= fill_nxt;
        end
    end

    // Packet FSM, message bookkeeping and the sequence number
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            seq_num    <= SEQ_NUM_W'(1);
            msgs_left  <= '0;
            bytes_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pkt_fire) begin
                        if ((pkt_msg_cnt_i == '0) || (pkt_msg_cnt_i == EOS_MSG_CNT)) begin
                            state <= ST_DRAIN;
                        end else begin
                            msgs_left <= pkt_msg_cnt_i;
                            seq_num   <= seq_num + SEQ_NUM_W'(pkt_msg_cnt_i);
                            state     <= ST_MSG;
                        end
                    end
                    if (seq_num_load_v_i) seq_num <= seq_num_load_i;
                end
                ST_MSG: begin
                    if (msg_fire) begin
                        bytes_left <= bytes_rem;
                        if (bytes_rem == '0) begin
                            msgs_left <= msgs_left - 1'b1;
                            if (msgs_left == ML_W'(1)) state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop_fire && (fill <= 5'd8)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moldudp64_tx.sv
`timescale 1ns/1ps
// tb_moldudp64_tx: scoreboard bench for the MoldUDP64 packetizer.
// The expected byte stream of each packet is built as a flat byte list and
// chopped into beats queued for a monitor that checks every accepted beat.
module tb_moldudp64_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_v_i;
    logic [79:0] pkt_sid_i;
    logic [15:0] pkt_msg_cnt_i;
    logic        pkt_ready_o;
    logic        seq_num_load_v_i;
    logic [63:0] seq_num_load_i;
    logic [63:0] seq_num_o;
    logic        mold_msg_v_i;
    logic        mold_msg_start_i;
    logic [15:0] mold_msg_len_i;
    logic [7:0]  mold_msg_mask_i;
    logic [63:0] mold_msg_data_i;
    logic        mold_msg_ready_o;
    logic        udp_axis_tvalid_o;
    logic [7:0]  udp_axis_tkeep_o;
    logic [63:0] udp_axis_tdata_o;
    logic        udp_axis_tlast_o;
    logic        udp_axis_tuser_o;
    logic        udp_axis_tready_i;

    moldudp64_tx dut (
        .clk               (clk),
        .reset             (reset),
        .pkt_v_i           (pkt_v_i),
        .pkt_sid_i         (pkt_sid_i),
        .pkt_msg_cnt_i     (pkt_msg_cnt_i),
        .pkt_ready_o       (pkt_ready_o),
        .seq_num_load_v_i  (seq_num_load_v_i),
        .seq_num_load_i    (seq_num_load_i),
        .seq_num_o         (seq_num_o),
        .mold_msg_v_i      (mold_msg_v_i),
        .mold_msg_start_i  (mold_msg_start_i),
        .mold_msg_len_i    (mold_msg_len_i),
        .mold_msg_mask_i   (mold_msg_mask_i),
        .mold_msg_data_i   (mold_msg_data_i),
        .mold_msg_ready_o  (mold_msg_ready_o),
        .udp_axis_tvalid_o (udp_axis_tvalid_o),
        .udp_axis_tkeep_o  (udp_axis_tkeep_o),
        .udp_axis_tdata_o  (udp_axis_tdata_o),
        .udp_axis_tlast_o  (udp_axis_tlast_o),
        .udp_axis_tuser_o  (udp_axis_tuser_o),
        .udp_axis_tready_i (udp_axis_tready_i)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       held;
    beat_t       mon_e;
    int          lens_q[$];
    logic [7:0]  data_q[$];
    int          total = 0;
    int          bad = 0;
    int          beats_seen = 0;
    int          model_fill = 0;
    int          mon_pushed;
    int          mon_popped;
    int          base;
    int          guard;
    bit          msgs_pending = 1'b0;
    bit          prev_stall = 1'b0;
    int          tready_mode = 0;
    logic [63:0] model_seq = 64'd1;
    logic [63:0] ld;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Backpressure generator: always ready, toggling, or random
    initial begin
        udp_axis_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       udp_axis_tready_i = 1'b1;
                1:       udp_axis_tready_i = ~udp_axis_tready_i;
                default: udp_axis_tready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: checks accepted beats, stalled-beat stability and input ready vs fill
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    checkOutput("hold_beat",
                                128'({udp_axis_tdata_o, udp_axis_tkeep_o, udp_axis_tlast_o}),
                                128'(held));
                mon_pushed = 0;
                mon_popped = 0;
                if (udp_axis_tvalid_o) checkOutput("tuser", 128'(udp_axis_tuser_o), 128'd0);
                if (udp_axis_tvalid_o && udp_axis_tready_i) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_beat: got data %016h, no beat required", udp_axis_tdata_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("beat_data", 128'(udp_axis_tdata_o), 128'(mon_e.data));
                        checkOutput("beat_keep", 128'(udp_axis_tkeep_o), 128'(mon_e.keep));
                        checkOutput("beat_last", 128'(udp_axis_tlast_o), 128'(mon_e.last));
                        mon_popped = $countones(mon_e.keep);
                    end
                    beats_seen++;
                end
                if (pkt_v_i && pkt_ready_o) mon_pushed += 20;
                if (mold_msg_v_i && mold_msg_ready_o)
                    mon_pushed += (mold_msg_start_i ? 2 : 0) + $countones(mold_msg_mask_i);
                if (mold_msg_ready_o) begin
                    checkOutput("ready_fill", 128'(model_fill <= 14), 128'd1);
                    checkOutput("ready_pending", 128'(msgs_pending), 128'd1);
                end
                model_fill = model_fill + mon_pushed - mon_popped;
                prev_stall = udp_axis_tvalid_o && !udp_axis_tready_i;
                held = {udp_axis_tdata_o, udp_axis_tkeep_o, udp_axis_tlast_o};
            end
        end
    end

    // Drive one message beat and hold it until accepted
    task automatic drive_msg_beat(input bit start, input logic [15:0] len, input logic [7:0] mask,
                                  input logic [63:0] data);
        bit acc;
        int g = 0;
        mold_msg_v_i     = 1'b1;
        mold_msg_start_i = start;
        mold_msg_len_i   = len;
        mold_msg_mask_i  = mask;
        mold_msg_data_i  = data;
        do begin
            @(negedge clk);
            acc = mold_msg_ready_o;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 1000);
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL msg_accept_timeout: got no ready, required ready within 1000 cycles");
        end
        mold_msg_v_i = 1'b0;
    endtask

    // Build the expected packet, queue its beats, then drive descriptor and messages
    task automatic applyStimulus(input logic [79:0] sid, input logic [15:0] cnt, input bit do_load,
                                 input logic [63:0] load_val, input bit eos_poke, input int abort_after);
        logic [7:0]  bq[$];
        logic [63:0] new_seq;
        logic [63:0] d;
        bit          normal;
        bit          acc;
        int          g;
        int          n;
        int          rem;
        bit          first;
        normal = (cnt != 16'd0) && (cnt != 16'hFFFF);
        data_q.delete();
        for (int i = 0; i < 10; i++) bq.push_back(sid[79-8*i -: 8]);
        for (int i = 0; i < 8; i++) bq.push_back(model_seq[63-8*i -: 8]);
        bq.push_back(cnt[15:8]);
        bq.push_back(cnt[7:0]);
        if (normal) begin
            for (int m = 0; m < lens_q.size(); m++) begin
                bq.push_back(8'(lens_q[m] >> 8));
                bq.push_back(8'(lens_q[m]));
                for (int b = 0; b < lens_q[m]; b++) begin
                    logic [7:0] r;
                    r = 8'($urandom);
                    bq.push_back(r);
                    data_q.push_back(r);
                end
            end
        end
        for (int b = 0; b < bq.size(); b += 8) begin
            beat_t e;
            e = '0;
            for (int l = 0; l < 8; l++) begin
                if (b + l < bq.size()) begin
                    e.data[8*l +: 8] = bq[b+l];
                    e.keep[l] = 1'b1;
                end
            end
            e.last = (b + 8 >= bq.size());
            exp_q.push_back(e);
        end
        new_seq = normal ? model_seq + 64'(cnt) : model_seq;
        if (do_load) new_seq = load_val;
        msgs_pending = normal;

        g = 0;
        while (!pkt_ready_o && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        pkt_v_i          = 1'b1;
        pkt_sid_i        = sid;
        pkt_msg_cnt_i    = cnt;
        seq_num_load_v_i = do_load;
        seq_num_load_i   = load_val;
        g = 0;
        do begin
            @(negedge clk);
            acc = pkt_ready_o;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 500);
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL pkt_accept_timeout: got no pkt_ready, required within 500 cycles");
        end
        pkt_v_i          = 1'b0;
        seq_num_load_v_i = 1'b0;
        model_seq        = new_seq;

        if (normal) begin
            for (int m = 0; m < lens_q.size(); m++) begin
                if (abort_after >= 0 && m == abort_after) return;
                rem   = lens_q[m];
                first = 1'b1;
                do begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    n = (rem > 8) ? 8 : rem;
                    d = '0;
                    for (int l = 0; l < n; l++) d[8*l +: 8] = data_q.pop_front();
                    drive_msg_beat(first, 16'(lens_q[m]), 8'((1 << n) - 1), d);
                    rem   = rem - n;
                    first = 1'b0;
                end while (rem > 0);
            end
        end
        msgs_pending = 1'b0;

        if (eos_poke) begin
            mold_msg_v_i     = 1'b1;
            mold_msg_start_i = 1'b1;
            mold_msg_len_i   = 16'd5;
            mold_msg_mask_i  = 8'h1F;
            mold_msg_data_i  = 64'h0000_0011_2233_4455;
        end
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        mold_msg_v_i = 1'b0;
        checkOutput("seq_num", 128'(seq_num_o), 128'(model_seq));
        checkOutput("pkt_ready_after", 128'(pkt_ready_o), 128'd1);
    endtask

    task automatic check_reset_values();
        checkOutput("rst_tvalid", 128'(udp_axis_tvalid_o), 128'd0);
        checkOutput("rst_tlast", 128'(udp_axis_tlast_o), 128'd0);
        checkOutput("rst_tkeep", 128'(udp_axis_tkeep_o), 128'd0);
        checkOutput("rst_tdata", 128'(udp_axis_tdata_o), 128'd0);
        checkOutput("rst_tuser", 128'(udp_axis_tuser_o), 128'd0);
        checkOutput("rst_msg_ready", 128'(mold_msg_ready_o), 128'd0);
        checkOutput("rst_pkt_ready", 128'(pkt_ready_o), 128'd1);
        checkOutput("rst_seq", 128'(seq_num_o), 128'd1);
    endtask

    initial begin
        reset            = 1'b1;
        pkt_v_i          = 1'b0;
        pkt_sid_i        = '0;
        pkt_msg_cnt_i    = '0;
        seq_num_load_v_i = 1'b0;
        seq_num_load_i   = '0;
        mold_msg_v_i     = 1'b0;
        mold_msg_start_i = 1'b0;
        mold_msg_len_i   = '0;
        mold_msg_mask_i  = '0;
        mold_msg_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values();

        seq_num_load_v_i = 1'b1;
        seq_num_load_i   = 64'hF0F0_F0F0_F0F0_F0F0;
        @(posedge clk);
        #1;
        seq_num_load_v_i = 1'b0;
        model_seq = 64'hF0F0_F0F0_F0F0_F0F0;
        checkOutput("seq_load", 128'(seq_num_o), 128'(64'hF0F0_F0F0_F0F0_F0F0));

        // Three-message packet: 61 bytes in 8 beats
        lens_q = {16, 8, 11};
        base = beats_seen;
        applyStimulus(80'h0000_0000_0000_DEAD_BEEF, 16'd3, 1'b0, 64'd0, 1'b0, -1);
        checkOutput("three_msg_beats", 128'(beats_seen - base), 128'd8);
        checkOutput("three_msg_seq", 128'(seq_num_o), 128'(64'hF0F0_F0F0_F0F0_F0F3));

        // Heartbeat
        lens_q.delete();
        base = beats_seen;
        applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'd0, 1'b0, 64'd0, 1'b0, -1);
        checkOutput("heartbeat_beats", 128'(beats_seen - base), 128'd3);

        // End of session with message input offered during the drain
        base = beats_seen;
        applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'hFFFF, 1'b0, 64'd0, 1'b1, -1);
        checkOutput("eos_beats", 128'(beats_seen - base), 128'd3);

        // Zero-length message: 22 bytes in 3 beats
        lens_q = {0};
        base = beats_seen;
        applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'd1, 1'b0, 64'd0, 1'b0, -1);
        checkOutput("zero_len_beats", 128'(beats_seen - base), 128'd3);

        // Backpressure on the three-message packet
        tready_mode = 1;
        lens_q = {16, 8, 11};
        applyStimulus(80'h0000_0000_0000_DEAD_BEEF, 16'd3, 1'b0, 64'd0, 1'b0, -1);

        // Load in the same cycle as a descriptor accept
        tready_mode = 2;
        lens_q = {5, 9};
        ld = {$urandom, $urandom};
        applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'd2, 1'b1, ld, 1'b0, -1);

        // Random packets under random backpressure
        for (int r = 0; r < 8; r++) begin
            int c;
            c = $urandom_range(1, 4);
            lens_q.delete();
            for (int m = 0; m < c; m++) lens_q.push_back($urandom_range(0, 24));
            applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'(c), 1'b0, 64'd0, 1'b0, -1);
        end

        // Reset mid-packet after the 4th output beat
        tready_mode = 0;
        lens_q = {16, 8, 11};
        base = beats_seen;
        applyStimulus(80'h0000_0000_0000_DEAD_BEEF, 16'd3, 1'b0, 64'd0, 1'b0, 1);
        guard = 0;
        while (beats_seen < base + 4 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("beats_before_reset", 128'(beats_seen - base), 128'd4);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        model_fill   = 0;
        model_seq    = 64'd1;
        msgs_pending = 1'b0;
        mold_msg_v_i = 1'b0;
        pkt_v_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        lens_q.delete();
        applyStimulus({$urandom, $urandom, 16'($urandom)}, 16'd0, 1'b0, 64'd0, 1'b0, -1);

        checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
